capt_count_gen: RTL and testbench
=================================

Name: capt_count_gen

Overview:
Parametrised capture counter: the next generation of the lab capture counter. It applies one of four ops (hold, increment, decrement, clear) on each clock edge where capture is high. It adds configurable width and terminal count, a selectable wrap or saturate mode, a parallel load, a programmable almost-full threshold, and sticky overflow/underflow flags. It sits in the lab datapath wherever the 2-bit op/capture counter is instantiated, with the full output keeping the same meaning.

Parameters:
WIDTH, 8, counter width in bits (2..32)
MAX_COUNT, 2**WIDTH-1, terminal count; legal range 1..2**WIDTH-1
SAT_MODE, 1, 1 = saturate at 0/MAX_COUNT; 0 = wrap modulo MAX_COUNT+1
AF_DEFAULT, MAX_COUNT-1, reset value of the almost-full threshold register

Ports:
clock  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
capture  input  1  qualifies op; when low, counter holds
op  input  2  00 hold, 01 increment, 10 decrement, 11 clear
load  input  1  parallel load strobe; has priority over capture/op
load_val  input  WIDTH  value to load; clamped to MAX_COUNT
thr_we  input  1  write enable for almost-full threshold
thr_val  input  WIDTH  new threshold; clamped to MAX_COUNT
count  output  WIDTH  current count (registered)
full  output  1  count == MAX_COUNT
empty  output  1  count == 0
almost_full  output  1  count >= threshold register
ovf  output  1  sticky: an increment was attempted at MAX_COUNT
unf  output  1  sticky: a decrement was attempted at 0

Behaviour:
- Reset (rst_n low, asynchronous assert; release takes effect on the next clock):
  - count = 0, threshold = AF_DEFAULT, ovf = 0, unf = 0.
  - Therefore full = 0, empty = 1, almost_full = (AF_DEFAULT == 0).
  - Reset asserted mid-operation overrides everything immediately.
- Priority per rising edge: load > (capture & op) > hold.
- load = 1: count <= min(load_val, MAX_COUNT). Sticky flags are unchanged.
- capture = 0 and load = 0: count holds. op is ignored.
- capture = 1, op = 00: count holds.
- capture = 1, op = 01 (increment):
  - count < MAX_COUNT: count + 1.
  - count == MAX_COUNT and SAT_MODE = 1: count stays, ovf <= 1.
  - count == MAX_COUNT and SAT_MODE = 0: count <= 0, ovf <= 1.
- capture = 1, op = 10 (decrement):
  - count > 0: count - 1.
  - count == 0 and SAT_MODE = 1: count stays, unf <= 1.
  - count == 0 and SAT_MODE = 0: count <= MAX_COUNT, unf <= 1.
- capture = 1, op = 11 (clear): count <= 0, ovf <= 0, unf <= 0. This is the only non-reset way to clear the sticky flags.
- Threshold: on thr_we, threshold <= min(thr_val, MAX_COUNT). This is independent of, and may coincide with, a count update.
- full, empty and almost_full are combinational decodes of the registered count and threshold. They are valid in the same cycle count changes (zero latency after the edge), so there is no extra pipeline stage.
- almost_full uses the threshold value after the edge: a thr_we and a count change on the same edge both take effect before the compare.
- All arithmetic is unsigned WIDTH bits, with no intermediate carry-out exposed. MAX_COUNT < 2**WIDTH-1 must wrap/saturate at MAX_COUNT, not at the natural WIDTH rollover.
- Outputs are never X after reset; inputs that are X while capture = 0 and load = 0 must not disturb state.

Test Plan:
- Reset then idle (WIDTH=4, MAX_COUNT=9, SAT_MODE=1): rst_n low 10 ns -> count=0, empty=1, full=0, ovf=unf=0. capture=0 with op=01 for 3 cycles -> count stays 0.
- Saturating increment (same config): capture=1, op=01 for 12 cycles -> count reaches 9 after 9 edges, full=1. Edge 10 sets ovf=1 with count held at 9. Then op=11 -> count=0, ovf=0, empty=1.
- Wrap mode (WIDTH=4, MAX_COUNT=9, SAT_MODE=0): from 0, op=10 once -> count=9, unf=1, full=1. Then op=01 once -> count=0, unf still 1.
- Load and threshold: thr_we=1 with thr_val=15 -> threshold clamps to 9, almost_full=0 at count 3. load=1 with load_val=12 and op=10 on the same edge -> count=9 (load wins, clamped), full=1, almost_full=1.
- Async reset mid-count: count=6 with incrementing, drop rst_n between edges -> count=0 immediately, before the next edge. Release rst_n -> the first increment yields 1 and threshold is back to AF_DEFAULT.
- Default params (WIDTH=8): 255 increments -> full=1. A 256th increment -> count 255 and ovf=1. op=10 -> count=254 and full=0, with ovf still 1.

Source files
------------

// File: rtl/capt_count_gen.sv
// Parametrised capture counter with wrap/saturate modes, parallel load,
// programmable almost-full threshold and sticky overflow/underflow flags.
module capt_count_gen #(
  parameter int unsigned      WIDTH      = 8,
  parameter longint unsigned  MAX_COUNT  = (64'd1 << WIDTH) - 64'd1,
  parameter bit               SAT_MODE   = 1'b1,
  parameter longint unsigned  AF_DEFAULT = MAX_COUNT - 64'd1
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             capture,
  input  logic [1:0]       op,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             thr_we,
  input  logic [WIDTH-1:0] thr_val,
  output logic [WIDTH-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] AF_V  = WIDTH'(AF_DEFAULT);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] thr_q, thr_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  // Next-state: load beats a captured op; op wraps or saturates at the terminal count.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (load) begin
      count_d = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (capture) begin
      case (op)
        OP_INC: begin
          if (count_q < MAX_V) begin
            count_d = count_q + ONE_V;
          end else begin
            ovf_d   = 1'b1;
            count_d = SAT_MODE ? MAX_V : '0;
          end
        end
        OP_DEC: begin
          if (count_q != '0) begin
            count_d = count_q - ONE_V;
          end else begin
            unf_d   = 1'b1;
            count_d = SAT_MODE ? '0 : MAX_V;
          end
        end
        OP_CLR: begin
          count_d = '0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
        end
        OP_HOLD: count_d = count_q;
        default: count_d = count_q;
      endcase
    end
  end

  // Threshold update is independent of the counter path.
  always_comb begin
    thr_d = thr_q;
    if (thr_we) begin
      thr_d = (thr_val > MAX_V) ? MAX_V : thr_val;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      thr_q   <= AF_V;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      thr_q   <= thr_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Status decodes of the registered count, valid in the same cycle.
  always_comb begin
    count       = count_q;
    ovf         = ovf_q;
    unf         = unf_q;
    full        = (count_q == MAX_V);
    empty       = (count_q == '0);
    almost_full = (count_q >= thr_q);
  end

endmodule

// File: tb/tb_capt_count_gen.sv
// Directed bench for capt_count_gen: saturating, wrapping and default-width instances.
module tb_capt_count_gen;

  logic       clock = 1'b0;
  logic       rst_a = 1'b0;
  logic       rst_b = 1'b0;
  logic       rst_c = 1'b0;
  logic       capture = 1'b0;
  logic [1:0] op = 2'b00;
  logic       load = 1'b0;
  logic [7:0] load_val = '0;
  logic       thr_we = 1'b0;
  logic [7:0] thr_val = '0;

  logic [3:0] count_a, count_b;
  logic [7:0] count_c;
  logic full_a, empty_a, af_a, ovf_a, unf_a;
  logic full_b, empty_b, af_b, ovf_b, unf_b;
  logic full_c, empty_c, af_c, ovf_c, unf_c;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  capt_count_gen #(.WIDTH(4), .MAX_COUNT(9), .SAT_MODE(1'b1)) u_sat (
    .clock(clock), .rst_n(rst_a), .capture(capture), .op(op), .load(load),
    .load_val(load_val[3:0]), .thr_we(thr_we), .thr_val(thr_val[3:0]),
    .count(count_a), .full(full_a), .empty(empty_a), .almost_full(af_a),
    .ovf(ovf_a), .unf(unf_a)
  );

  capt_count_gen #(.WIDTH(4), .MAX_COUNT(9), .SAT_MODE(1'b0)) u_wrap (
    .clock(clock), .rst_n(rst_b), .capture(capture), .op(op), .load(load),
    .load_val(load_val[3:0]), .thr_we(thr_we), .thr_val(thr_val[3:0]),
    .count(count_b), .full(full_b), .empty(empty_b), .almost_full(af_b),
    .ovf(ovf_b), .unf(unf_b)
  );

  capt_count_gen u_dflt (
    .clock(clock), .rst_n(rst_c), .capture(capture), .op(op), .load(load),
    .load_val(load_val), .thr_we(thr_we), .thr_val(thr_val),
    .count(count_c), .full(full_c), .empty(empty_c), .almost_full(af_c),
    .ovf(ovf_c), .unf(unf_c)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_count", count_a, 0);
    chk("rst_empty", empty_a, 1);
    chk("rst_full", full_a, 0);
    chk("rst_af", af_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_unf", unf_a, 0);
    rst_a = 1'b1;

    // Idle: op ignored without capture
    capture = 1'b0; op = 2'b01;
    step(3);
    chk("idle_count", count_a, 0);

    // Saturating increment
    capture = 1'b1; op = 2'b01;
    step(7);
    chk("inc7_count", count_a, 7);
    chk("inc7_af", af_a, 0);
    step(1);
    chk("inc8_af", af_a, 1);
    chk("inc8_full", full_a, 0);
    step(1);
    chk("inc9_count", count_a, 9);
    chk("inc9_full", full_a, 1);
    chk("inc9_ovf", ovf_a, 0);
    step(1);
    chk("inc10_count", count_a, 9);
    chk("inc10_ovf", ovf_a, 1);
    step(2);
    chk("inc12_count", count_a, 9);
    op = 2'b11;
    step(1);
    chk("clr_count", count_a, 0);
    chk("clr_ovf", ovf_a, 0);
    chk("clr_empty", empty_a, 1);

    // Wrap mode
    rst_b = 1'b1;
    op = 2'b10;
    step(1);
    chk("wrap_dec_count", count_b, 9);
    chk("wrap_dec_unf", unf_b, 1);
    chk("wrap_dec_full", full_b, 1);
    op = 2'b01;
    step(1);
    chk("wrap_inc_count", count_b, 0);
    chk("wrap_inc_unf", unf_b, 1);
    chk("wrap_inc_ovf", ovf_b, 1);
    chk("wrap_inc_empty", empty_b, 1);

    // Load and threshold clamping
    capture = 1'b0;
    load = 1'b1; load_val = 8'd3; thr_we = 1'b1; thr_val = 8'd15;
    step(1);
    thr_we = 1'b0;
    chk("ld3_count", count_b, 3);
    chk("ld3_af", af_b, 0);
    capture = 1'b1; op = 2'b10; load_val = 8'd12;
    step(1);
    chk("ld12_count", count_b, 9);
    chk("ld12_full", full_b, 1);
    chk("ld12_af", af_b, 1);
    chk("ld12_unf", unf_b, 1);
    load_val = 8'd5; thr_we = 1'b1; thr_val = 8'd5;
    step(1);
    thr_we = 1'b0;
    chk("ld5_count", count_b, 5);
    chk("ld5_af_same_edge", af_b, 1);

    // Asynchronous reset mid-count
    load = 1'b0; op = 2'b01;
    step(1);
    chk("pre_rst_count", count_b, 6);
    #2 rst_b = 1'b0;
    #1;
    chk("async_count", count_b, 0);
    chk("async_empty", empty_b, 1);
    chk("async_ovf", ovf_b, 0);
    chk("async_unf", unf_b, 0);
    #1 rst_b = 1'b1;
    step(1);
    chk("post_rst_count", count_b, 1);
    load = 1'b1; load_val = 8'd7;
    step(1);
    chk("thr_dflt_7", af_b, 0);
    load_val = 8'd8;
    step(1);
    chk("thr_dflt_8", af_b, 1);
    load = 1'b0;

    // Default parameters, WIDTH=8
    rst_c = 1'b1;
    capture = 1'b1; op = 2'b01;
    step(254);
    chk("d254_count", count_c, 254);
    chk("d254_full", full_c, 0);
    chk("d254_af", af_c, 1);
    step(1);
    chk("d255_count", count_c, 255);
    chk("d255_full", full_c, 1);
    chk("d255_ovf", ovf_c, 0);
    step(1);
    chk("d256_count", count_c, 255);
    chk("d256_ovf", ovf_c, 1);
    op = 2'b10;
    step(1);
    chk("ddec_count", count_c, 254);
    chk("ddec_full", full_c, 0);
    chk("ddec_ovf", ovf_c, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
